// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// The fetch stage is the master; the memory (or its model) is the slave.
interface if_fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_rvalid, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_rvalid, imem_rdata);
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches over if_fetch_stage_if, holds the IR.
// Define IF_FETCH_PERF_EN to add the fetch_count/stall_count performance counters.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MAX_WAIT  = 8,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                   clk,
  input  logic                   rst_n,
  if_fetch_stage_if.master       imem,
  input  logic                   stall,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_pc,
  output logic                   if_valid,
  output logic [31:0]            if_pc,
  output logic [31:0]            if_instr,
  output logic [6:0]             op,
  output logic [2:0]             func3,
  output logic [6:0]             func7,
  output logic                   misalign_err,
  output logic                   fetch_err
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [31:0]            fetch_count,
  output logic [31:0]            stall_count
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_VALID, S_DRAIN} state_e;

  localparam logic [7:0] MAX_W8 = MAX_WAIT[7:0];

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [7:0]  cnt_q, cnt_d, cnt_inc;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic        misalign_q, misalign_d;
  logic        fetch_err_q, fetch_err_d;
  logic        redir;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    cnt_d       = cnt_q;
    if_valid_d  = if_valid_q;
    if_pc_d     = if_pc_q;
    if_instr_d  = if_instr_q;
    fetch_err_d = fetch_err_q;
    misalign_d  = 1'b0;
    redir       = redirect_valid && (state_q != S_IDLE);
    cnt_inc     = cnt_q + 8'd1;

    unique case (state_q)
      S_IDLE:  state_d = S_FETCH;
      // A request leaves this cycle no matter what, so a redirect must drain it.
      S_FETCH: begin
        cnt_d   = '0;
        state_d = redir ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        if (imem.imem_rvalid) begin
          state_d = S_FETCH;
          if (!redir) begin
            if_instr_d = imem.imem_rdata;
            if_pc_d    = pc_q;
            if_valid_d = 1'b1;
            state_d    = S_VALID;
          end
        end else if (redir) begin
          cnt_d   = '0;
          state_d = S_DRAIN;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == MAX_W8) begin
            fetch_err_d = 1'b1;
            state_d     = S_FETCH;
          end
        end
      end
      S_VALID: begin
        if (redir) begin
          state_d = S_FETCH;
        end else if (!stall) begin
          pc_d       = pc_q + 32'd4;
          if_valid_d = 1'b0;
          if_instr_d = NOP_INSTR;
          state_d    = S_FETCH;
        end
      end
      // Stale response is owed; redirects here only move the PC.
      S_DRAIN: begin
        if (imem.imem_rvalid) begin
          state_d = S_FETCH;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == MAX_W8) state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (redir) begin
      pc_d       = redirect_pc & ~32'h3;
      if_valid_d = 1'b0;
      if_instr_d = NOP_INSTR;
      misalign_d = |redirect_pc[1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      cnt_q       <= '0;
      if_valid_q  <= 1'b0;
      if_pc_q     <= '0;
      if_instr_q  <= NOP_INSTR;
      misalign_q  <= 1'b0;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      cnt_q       <= cnt_d;
      if_valid_q  <= if_valid_d;
      if_pc_q     <= if_pc_d;
      if_instr_q  <= if_instr_d;
      misalign_q  <= misalign_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  assign imem.imem_req  = (state_q == S_FETCH);
  assign imem.imem_addr = (state_q == S_FETCH) ? pc_q : '0;
  assign if_valid       = if_valid_q;
  assign if_pc          = if_pc_q;
  assign if_instr       = if_instr_q;
  assign op             = if_instr_q[6:0];
  assign func3          = if_instr_q[14:12];
  assign func7          = if_instr_q[31:25];
  assign misalign_err   = misalign_q;
  assign fetch_err      = fetch_err_q;

`ifdef IF_FETCH_PERF_EN
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] stall_count_q, stall_count_d;

  always_comb begin
    fetch_count_d = fetch_count_q;
    stall_count_d = stall_count_q;
    if (state_q == S_VALID && !stall && !redir) fetch_count_d = fetch_count_q + 32'd1;
    if (state_q == S_VALID && stall)            stall_count_d = stall_count_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count_q <= '0;
      stall_count_q <= '0;
    end else begin
      fetch_count_q <= fetch_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign fetch_count = fetch_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule
